// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-ported
// data memory. Requester 0 is the core load/store path and requester 1 is the
// loader/debug path.
//
// Grants are combinational and the memory port is driven in the same cycle.
// The memory commits writes on the falling edge and reads combinationally.
// Read data is registered per requester and returned one cycle after the grant.
//
// Optional feature: define DMEM_ARB_LOCK_EN to let the current owner keep the
// port through m0_lock/m1_lock. The owner can hold it for at most LOCK_MAX
// consecutive grants while the other side is waiting. Without the macro, the
// lock inputs are ignored and arbitration is pure round-robin.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_lock,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_lock,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

   owner_t owner;   // requester granted in the previous cycle
   logic   prio;    // requester that wins the next contended cycle
   logic   gnt0, gnt1;
   logic   hold0, hold1;  // owner keeps the port through its lock

`ifdef DMEM_ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

   // Number of consecutive locked grants to the current owner, including the
   // grant that made it the owner.
   logic [CNT_W-1:0] lock_cnt;

   assign hold0 = (owner == OWN0) && m0_req && m0_lock && (lock_cnt < LOCK_LIM);
   assign hold1 = (owner == OWN1) && m1_req && m1_lock && (lock_cnt < LOCK_LIM);

   // Track locked-grant runs; a new owner or an idle cycle starts over
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_cnt <= '0;
      end else if (gnt0 && m0_lock) begin
         if (owner != OWN0)
            lock_cnt <= CNT_W'(1);
         else if (lock_cnt < LOCK_LIM)
            lock_cnt <= lock_cnt + CNT_W'(1);
      end else if (gnt1 && m1_lock) begin
         if (owner != OWN1)
            lock_cnt <= CNT_W'(1);
         else if (lock_cnt < LOCK_LIM)
            lock_cnt <= lock_cnt + CNT_W'(1);
      end else begin
         lock_cnt <= '0;
      end
   end
`else
   logic unused_lock;

   assign hold0       = 1'b0;
   assign hold1       = 1'b0;
   assign unused_lock = m0_lock ^ m1_lock;
`endif

   // Pick at most one requester this cycle; nothing is granted while in reset
   always_comb begin
      // NOTE: default every output first so no path leaves a value held (latch).
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (hold0)
            gnt0 = 1'b1;
         else if (hold1)
            gnt1 = 1'b1;
         else if (m0_req && m1_req) begin
            if (prio) gnt1 = 1'b1;
            else      gnt0 = 1'b1;
         end else if (m0_req)
            gnt0 = 1'b1;
         else if (m1_req)
            gnt1 = 1'b1;
      end
   end

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign mem_addr  = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
   assign mem_wdata = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);
   assign mem_write = (gnt0 && m0_we)  || (gnt1 && m1_we);
   assign mem_read  = (gnt0 && !m0_we) || (gnt1 && !m1_we);

   // Owner FSM, round-robin pointer and registered read-return path
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner     <= IDLE;
         prio      <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         m0_rvalid <= gnt0 && !m0_we;
         m1_rvalid <= gnt1 && !m1_we;
         if (gnt0 && !m0_we) m0_rdata <= mem_rdata;
         if (gnt1 && !m1_we) m1_rdata <= mem_rdata;
         if (gnt0) begin
            owner <= OWN0;
            prio  <= 1'b1;
         end else if (gnt1) begin
            owner <= OWN1;
            prio  <= 1'b0;
         end else begin
            owner <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test of dmem_arbiter against a small behavioural
// memory. The memory writes on the negedge and reads combinationally.
// Inputs change 1 ns after each posedge. Grants are sampled 4 ns after the
// posedge, before the negedge. Registered outputs are sampled 1 ns after the
// posedge.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   int tests;
   int fails;

   logic [31:0] mem [0:15];
   logic [3:0]  mem_idx;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   // Memory model: combinational read, negedge write
   assign mem_idx   = 4'(mem_addr);
   assign mem_rdata = mem[mem_idx];
   always @(negedge clk) if (mem_write) mem[mem_idx] <= mem_wdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lock);
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
   endtask

   task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lock);
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
   endtask

   logic [4:0] exp_m1_seq;  // bit i: m1 expected to win lock-test cycle i

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
      mem[5] = 32'h23;
      mem[3] = 32'h0;
      reset = 1'b1;
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_m0_rvalid", m0_rvalid, 0);
      check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_m0_rdata",  m0_rdata,  0);
      check("rst_m1_rdata",  m1_rdata,  0);
      reset = 1'b0;

      // Single read by m0 from addr 5
      drive0(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);
      #3;
      check("rd5_m0_gnt",    m0_gnt,    1);
      check("rd5_m1_gnt",    m1_gnt,    0);
      check("rd5_mem_read",  mem_read,  1);
      check("rd5_mem_write", mem_write, 0);
      check("rd5_mem_addr",  mem_addr,  5);
      tick();
      check("rd5_m0_rvalid", m0_rvalid, 1);
      check("rd5_m0_rdata",  m0_rdata,  32'h23);
      check("rd5_m1_rvalid", m1_rvalid, 0);

      // Contended cycle: prio is now 1, so m1 wins; reset hits before the closing edge
      drive0(1'b1, 1'b0, 32'd1, 32'h0, 1'b0);
      drive1(1'b1, 1'b0, 32'd2, 32'h0, 1'b0);
      #2;
      check("cont_m1_gnt",  m1_gnt,   1);
      check("cont_m0_gnt",  m0_gnt,   0);
      check("cont_addr",    mem_addr, 2);
      reset = 1'b1;
      #1;
      check("mrst_m0_gnt",    m0_gnt,    0);
      check("mrst_m1_gnt",    m1_gnt,    0);
      check("mrst_mem_read",  mem_read,  0);
      check("mrst_mem_write", mem_write, 0);
      check("mrst_mem_addr",  mem_addr,  0);
      check("mrst_m0_rdata",  m0_rdata,  0);
      check("mrst_m0_rvalid", m0_rvalid, 0);
      tick();
      check("mrst_m1_rvalid", m1_rvalid, 0);
      check("mrst_m1_rdata",  m1_rdata,  0);
      reset = 1'b0;

      // Both read continuously: strict alternation starting with m0
      for (int i = 0; i < 6; i++) begin
         #3;
         check("rr_m0_gnt",   m0_gnt,   (i % 2) == 0);
         check("rr_m1_gnt",   m1_gnt,   (i % 2) == 1);
         check("rr_mem_read", mem_read, 1);
         check("rr_mem_addr", mem_addr, ((i % 2) == 1) ? 2 : 1);
         tick();
         check("rr_m0_rvalid", m0_rvalid, (i % 2) == 0);
         check("rr_m1_rvalid", m1_rvalid, (i % 2) == 1);
      end
      check("rr_m0_rdata", m0_rdata, 32'h101);
      check("rr_m1_rdata", m1_rdata, 32'h102);

      // m1 writes 0xAB to addr 3, then m0 reads it back
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      drive1(1'b1, 1'b1, 32'd3, 32'hAB, 1'b0);
      #3;
      check("wr_m1_gnt",    m1_gnt,    1);
      check("wr_mem_write", mem_write, 1);
      check("wr_mem_read",  mem_read,  0);
      check("wr_mem_addr",  mem_addr,  3);
      check("wr_mem_wdata", mem_wdata, 32'hAB);
      tick();
      check("wr_m1_rvalid", m1_rvalid, 0);
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      drive0(1'b1, 1'b0, 32'd3, 32'h0, 1'b0);
      #3;
      check("rb_m0_gnt",    m0_gnt,    1);
      check("rb_mem_write", mem_write, 0);
      check("rb_mem_read",  mem_read,  1);
      tick();
      check("rb_m0_rvalid", m0_rvalid, 1);
      check("rb_m0_rdata",  m0_rdata,  32'hAB);
      check("rb_m1_rvalid", m1_rvalid, 0);

      // Lock behaviour from a fresh reset: m0 req+lock, m1 req
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      exp_m1_seq = 5'b10000;
`else
      exp_m1_seq = 5'b01010;
`endif
      drive0(1'b1, 1'b0, 32'd0, 32'h0, 1'b1);
      drive1(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #3;
         check("lock_m1_gnt", m1_gnt, exp_m1_seq[i]);
         check("lock_m0_gnt", m0_gnt, !exp_m1_seq[i]);
         tick();
      end

      // Idle: nothing granted, memory port quiet
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #3;
      check("idle_gnt",      {m0_gnt, m1_gnt}, 0);
      check("idle_mem_read", mem_read, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
